prog_ctr: RTL and testbench

Program counter and run-control for the single-cycle CPU. It sits directly downstream of the branch-offset lookup table. It consumes the table's signed 8-bit relative offset together with decode's branch/halt strobes, and produces the instruction-memory address each cycle. It also provides the start/done handshake and a cycle counter used by the testbench.

---
 rtl/prog_ctr_pkg.sv | 17 +
 rtl/pc_ret_stack.sv | 55 +++++
 rtl/prog_ctr.sv | 170 +++++++++++++++++
 tb/tb_prog_ctr.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_ctr_pkg.sv
// prog_ctr_pkg: shared types and default sizes for the program counter
// and run-control block. The optional return-address stack is enabled
// by defining PROG_CTR_CALL_STACK_EN.
package prog_ctr_pkg;

  localparam int DEF_PC_W    = 10;
  localparam int DEF_OFF_W   = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: small LIFO holding return addresses for relative calls.
// Push is ignored when full and pop is ignored when empty; the caller
// decides how to flag those cases. i_clr empties the stack synchronously.
module pc_ret_stack
  import prog_ctr_pkg::*;
#(
  parameter int W     = DEF_PC_W,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_top_idx;

  // Write slot is the current fill level; top of stack is one below it.
  assign w_wr_idx  = AW'(r_cnt);
  assign w_top_idx = AW'(r_cnt - {{(CW-1){1'b0}}, 1'b1});
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == {CW{1'b0}});
  assign o_top     = r_mem[w_top_idx];

  // Fill level and storage; full/empty guards keep the count in range.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
    end else if (i_clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_data;
      r_cnt           <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else if (i_pop && !o_empty) begin
      r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/prog_ctr.sv
// prog_ctr: program counter and IDLE/RUN/HALTED run-control for the
// single-cycle CPU. Produces the instruction address each cycle from the
// branch/halt strobes and the signed relative offset, plus a saturating
// RUN-cycle counter. Define PROG_CTR_CALL_STACK_EN to add call/ret
// support through a return-address stack; otherwise call/ret are ignored
// and stack_err stays 0.
module prog_ctr
  import prog_ctr_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int OFF_W = DEF_OFF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_en,
  input  logic [OFF_W-1:0] offset,
  input  logic             call,
  input  logic             ret,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             stack_err
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_pc_br;
  logic [PC_W-1:0]   w_off_ext;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_clr;
  logic              w_call;
  logic              w_ret;
  logic              w_stk_full;
  logic              w_stk_empty;
  logic [PC_W-1:0]   w_stk_top;

  // Offsets are two's complement; sign-extend so the add wraps modulo 2^PC_W.
  assign w_off_ext = PC_W'($signed(offset));
  assign w_pc_inc  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_pc_br   = r_pc + w_off_ext;

`ifdef PROG_CTR_CALL_STACK_EN
  assign w_call = call;
  assign w_ret  = ret;

  pc_ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_stk_top),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty)
  );
`else
  // Without the stack, call/ret never reach the next-PC logic.
  logic w_unused;
  assign w_call      = 1'b0;
  assign w_ret       = 1'b0;
  assign w_stk_full  = 1'b0;
  assign w_stk_empty = 1'b1;
  assign w_stk_top   = {PC_W{1'b0}};
  assign w_unused    = &{1'b0, call, ret, w_push, w_pop, w_clr};
`endif

  // Next-state, next-PC and counter selection; RUN priority is
  // stall > halt > ret > call > branch > increment.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = {PC_W{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_err_nxt   = 1'b0;
          w_clr       = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RUN: begin
        if (r_cnt != {CNT_W{1'b1}}) begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_cnt_nxt = r_cnt;
        end
        if (stall) begin
          w_pc_nxt = r_pc;
        end else if (halt) begin
          w_pc_nxt    = r_pc;
          w_state_nxt = ST_HALTED;
        end else if (w_ret) begin
          if (!w_stk_empty) begin
            w_pc_nxt = w_stk_top;
            w_pop    = 1'b1;
          end else begin
            w_pc_nxt  = w_pc_inc;
            w_err_nxt = 1'b1;
          end
        end else if (w_call) begin
          // The jump is taken even when the return address cannot be saved.
          w_pc_nxt = w_pc_br;
          if (!w_stk_full) begin
            w_push = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (branch_en) begin
          w_pc_nxt = w_pc_br;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = {PC_W{1'b0}};
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_err_nxt   = 1'b0;
        w_clr       = 1'b1;
      end
    endcase
  end

  // Architectural state registers, cleared asynchronously by rst_n.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= {PC_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign pc        = r_pc;
  assign running   = (r_state == ST_RUN);
  assign done      = (r_state == ST_HALTED);
  assign cycle_cnt = r_cnt;
  assign stack_err = r_err;

endmodule

// File: tb/tb_prog_ctr.sv
// tb_prog_ctr: directed bench for prog_ctr. Expected output sets are
// queued as stimulus is applied and drained after the following clock
// edge. Define PROG_CTR_CALL_STACK_EN to also exercise call/ret.
module tb_prog_ctr;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        halt;
  logic        branch_en;
  logic [7:0]  offset;
  logic        call;
  logic        ret;
  logic [9:0]  pc;
  logic        running;
  logic        done;
  logic [15:0] cycle_cnt;
  logic        stack_err;

  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;
  int   m_cnt   = 0;
  logic m_err   = 1'b0;

  typedef struct {
    string       tag;
    logic [9:0]  pc;
    logic        run;
    logic        dn;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  prog_ctr dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .start     (start),
    .stall     (stall),
    .halt      (halt),
    .branch_en (branch_en),
    .offset    (offset),
    .call      (call),
    .ret       (ret),
    .pc        (pc),
    .running   (running),
    .done      (done),
    .cycle_cnt (cycle_cnt),
    .stack_err (stack_err)
  );

  task automatic push_exp(input string tag, input logic [9:0] p, input logic r,
                          input logic d, input logic [15:0] c, input logic e);
    exp_t x;
    x.tag = tag; x.pc = p; x.run = r; x.dn = d; x.cnt = c; x.err = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      n_total++;
      assert (pc === x.pc) n_pass++;
      else begin n_fail++; $error("FAIL %s pc: got %0d want %0d", x.tag, pc, x.pc); end
      n_total++;
      assert (running === x.run) n_pass++;
      else begin n_fail++; $error("FAIL %s running: got %b want %b", x.tag, running, x.run); end
      n_total++;
      assert (done === x.dn) n_pass++;
      else begin n_fail++; $error("FAIL %s done: got %b want %b", x.tag, done, x.dn); end
      n_total++;
      assert (cycle_cnt === x.cnt) n_pass++;
      else begin n_fail++; $error("FAIL %s cycle_cnt: got %0d want %0d", x.tag, cycle_cnt, x.cnt); end
      n_total++;
      assert (stack_err === x.err) n_pass++;
      else begin n_fail++; $error("FAIL %s stack_err: got %b want %b", x.tag, stack_err, x.err); end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    drain();
  endtask

  // One RUN cycle: counter advances, PC lands on the caller-given value.
  task automatic run_cyc(input string tag, input logic [9:0] exp_pc);
    m_cnt++;
    push_exp(tag, exp_pc, 1'b1, 1'b0, 16'(m_cnt), m_err);
    tick();
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    m_cnt = 0;
    m_err = 1'b0;
    push_exp(tag, 10'd0, 1'b1, 1'b0, 16'd0, 1'b0);
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
    branch_en = 1'b0; offset = 8'd0; call = 1'b0; ret = 1'b0;
    #12;
    push_exp("reset", 10'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    drain();
    @(negedge CLK);
    rst_n = 1'b1;
    push_exp("idle_no_start", 10'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    tick();

    do_start("start");
    for (int i = 1; i <= 20; i++) run_cyc("inc", 10'(i));

    branch_en = 1'b1;
    offset = 8'hF9; run_cyc("br_m7", 10'd13);
    offset = 8'd17; run_cyc("br_p17", 10'd30);
    offset = 8'hE5; run_cyc("br_m27", 10'd3);
    offset = 8'hF5; run_cyc("wrap_neg", 10'd1016);
    offset = 8'd0;  run_cyc("spin", 10'd1016);
    branch_en = 1'b0;
    for (int i = 1017; i <= 1023; i++) run_cyc("inc_hi", 10'(i));
    run_cyc("wrap_inc", 10'd0);
    for (int i = 1; i <= 8; i++) run_cyc("inc2", 10'(i));

    stall = 1'b1; branch_en = 1'b1; offset = 8'd5;
    run_cyc("stall_br", 10'd8);
    branch_en = 1'b0; halt = 1'b1;
    run_cyc("stall_halt", 10'd8);
    stall = 1'b0; halt = 1'b0;
    run_cyc("inc9", 10'd9);

    halt = 1'b1;
    m_cnt++;
    push_exp("halt", 10'd9, 1'b0, 1'b1, 16'(m_cnt), 1'b0);
    tick();
    halt = 1'b0; branch_en = 1'b1; offset = 8'd3;
    push_exp("halted_hold", 10'd9, 1'b0, 1'b1, 16'(m_cnt), 1'b0);
    tick();
    branch_en = 1'b0;

    do_start("restart");
    for (int i = 1; i <= 3; i++) run_cyc("inc3", 10'(i));
    start = 1'b1;
    run_cyc("start_in_run", 10'd4);
    start = 1'b0;
    branch_en = 1'b1; offset = 8'd36;
    run_cyc("br_40", 10'd40);
    branch_en = 1'b0;

    #2;
    rst_n = 1'b0;
    #1;
    push_exp("async_rst", 10'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    drain();
    @(negedge CLK);
    rst_n = 1'b1;
    push_exp("post_rst_idle", 10'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    tick();

`ifdef PROG_CTR_CALL_STACK_EN
    do_start("stk_start");
    call = 1'b1; offset = 8'd10;
    run_cyc("call1", 10'd10);
    run_cyc("call2", 10'd20);
    run_cyc("call3", 10'd30);
    run_cyc("call4", 10'd40);
    m_err = 1'b1;
    run_cyc("call5_ovf", 10'd50);
    ret = 1'b1;
    run_cyc("ret_wins", 10'd31);
    call = 1'b0;
    run_cyc("ret2", 10'd21);
    run_cyc("ret3", 10'd11);
    run_cyc("ret4", 10'd1);
    run_cyc("ret_empty", 10'd2);
    ret = 1'b0;
    halt = 1'b1;
    m_cnt++;
    push_exp("stk_halt", 10'd2, 1'b0, 1'b1, 16'(m_cnt), 1'b1);
    tick();
    halt = 1'b0;
    do_start("stk_restart_clr");
    ret = 1'b1;
    m_err = 1'b1;
    run_cyc("ret_after_clr", 10'd1);
    ret = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
